// File: rtl/rv32m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32m_pkg
// Description : Definitions shared by the RV32M divide/remainder unit:
//               funct3[1:0] operation encodings, FSM state enum and the
//               32-bit special-case constants.
// Revision    : 1.0  initial release
// ============================================================================
package rv32m_pkg;

    // funct3[1:0] of the M-extension divide group.
    // Bit 1 selects remainder, bit 0 selects unsigned.
    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage : rv32m_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. Shifts the
//               {rem, quo} pair left by one bit, trial-subtracts the divisor
//               and keeps the difference when it does not borrow. The freed
//               quotient LSB receives the new quotient bit.
// Ports       : rem_i      WIDTH+1  partial remainder
//               quo_i      WIDTH    dividend bits not yet consumed / quotient
//               divisor_i  WIDTH    divisor magnitude
//               rem_o      WIDTH+1  next partial remainder
//               quo_o      WIDTH    next quotient shift register
// Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // One extra bit above the shifted remainder so the subtract borrow
    // lands in the MSB of the difference.
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    always_comb begin
        w_shifted = {rem_i, quo_i[WIDTH-1]};
        w_diff    = w_shifted - {2'b00, divisor_i};
        w_fits    = ~w_diff[WIDTH+1];
        rem_o     = w_fits ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];
        quo_o     = {quo_i[WIDTH-2:0], w_fits};
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative RV32M DIV/DIVU/REM/REMU unit. Restoring
//               shift-subtract, one quotient bit per cycle, with RISC-V
//               divide-by-zero and signed-overflow semantics. Signed
//               operands are reduced to magnitudes at accept time and the
//               sign is restored in a single FIX cycle.
// Ports       : clk     in   clock, rising edge
//               reset   in   synchronous active-high reset
//               start   in   request, honoured only when not busy
//               op      in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//               A       in   dividend (rs1)
//               B       in   divisor  (rs2)
//               busy    out  iteration in progress, pipeline stall
//               done    out  one-cycle pulse, result valid
//               result  out  quotient/remainder, held until next result
// Revision    : 1.0  initial release
// ============================================================================
module div_unit
    import rv32m_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             is_rem_q;
    logic             sign_a_q;
    logic             sign_b_q;

    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] result_d;

    logic             w_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div_zero;
    logic             w_overflow;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Accept-time decode. Sign flags are forced low for unsigned ops so the
    // FIX stage needs no knowledge of signedness.
    always_comb begin
        w_signed   = ~op[0];
        w_sign_a   = w_signed & A[WIDTH-1];
        w_sign_b   = w_signed & B[WIDTH-1];
        // |INT_MIN| wraps to INT_MIN, which is the correct unsigned magnitude.
        w_mag_a    = w_sign_a ? -A : A;
        w_mag_b    = w_sign_b ? -B : B;
        w_div_zero = (B == '0);
        w_overflow = w_signed & (A == c_int_min) & (B == '1);
    end

    div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (div_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Quotient negated when operand signs differ; remainder follows A.
    always_comb begin
        w_quo_fix = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        w_rem_fix = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        result_d  = is_rem_q ? w_rem_fix : w_quo_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            is_rem_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new request exactly like IDLE so results can
                // be issued back to back.
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        is_rem_q <= op[1];
                        sign_a_q <= w_sign_a;
                        sign_b_q <= w_sign_b;
                        quo_q    <= w_mag_a;
                        div_q    <= w_mag_b;
                        rem_q    <= '0;
                        count_q  <= CNT_W'(WIDTH);
                        if (w_div_zero) begin
                            result_q <= op[1] ? A : '1;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else if (w_overflow) begin
                            result_q <= op[1] ? '0 : c_int_min;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit: latency, sign
//               handling, special cases, operand capture, reset abort and
//               back-to-back issue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request in the current cycle (cycle 0) and ends in the
    // cycle where done is expected, leaving start low.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit special);
        int bad;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!special) begin
            bad = 0;
            for (int c = 1; c <= 33; c++) begin
                if ({busy, done} !== 2'b10) bad++;
                tick();
            end
            check({tag, " busy-window bad cycles"}, bad, 32'd0);
        end
        check({tag, " busy/done"}, {30'd0, busy, done}, 32'd1);
        check({tag, " result"}, result, exp);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        op    = DIV_OP;
        A     = '0;
        B     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy/done", {30'd0, busy, done}, 32'd0);
        check("reset result", result, 32'd0);

        // Unsigned and signed arithmetic, normal 34-cycle latency.
        run_op("DIVU 100/7", DIVU_OP, 32'd100, 32'd7, 32'd14, 1'b0);
        tick();
        check("done pulse width", {31'd0, done}, 32'd0);
        check("result held", result, 32'd14);
        run_op("REMU 100/7", REMU_OP, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("DIV -7/2", DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("REM -7/2", REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("REM 7/-2", REM_OP, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_op("DIV -100/-7", DIV_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
        run_op("REM -100/-7", REM_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        run_op("DIVU max/16", DIVU_OP, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0);
        run_op("REMU max/16", REMU_OP, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 1'b0);
        run_op("DIV INT_MIN/2", DIV_OP, INT_MIN, 32'd2, 32'hC000_0000, 1'b0);
        run_op("DIVU 5/9", DIVU_OP, 32'd5, 32'd9, 32'd0, 1'b0);

        // Special cases: result in cycle 1, busy never raised.
        run_op("DIVU x/0", DIVU_OP, 32'h0000_1234, 32'd0, ALL_ONES, 1'b1);
        run_op("REMU x/0", REMU_OP, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1);
        run_op("DIV ovf", DIV_OP, INT_MIN, ALL_ONES, INT_MIN, 1'b1);
        run_op("REM ovf", REM_OP, INT_MIN, ALL_ONES, 32'd0, 1'b1);
        run_op("REM -5/0", REM_OP, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
        tick();
        check("special done pulse width", {30'd0, busy, done}, 32'd0);

        // Operand capture: stray start and operand changes mid-operation.
        op    = DIVU_OP;
        A     = 32'd1000;
        B     = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        op    = REMU_OP;
        A     = 32'd5;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'd1;
        bad   = 0;
        for (int c = 6; c <= 33; c++) begin
            if ({busy, done} !== 2'b10) bad++;
            tick();
        end
        check("capture busy-window bad cycles", bad, 32'd0);
        check("capture busy/done", {30'd0, busy, done}, 32'd1);
        check("capture result", result, 32'd100);
        tick();
        check("capture idle after done", {30'd0, busy, done}, 32'd0);

        // Reset in cycle 10 of an operation.
        op    = DIVU_OP;
        A     = 32'd50;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midop reset busy/done", {30'd0, busy, done}, 32'd0);
        check("midop reset result", result, 32'd0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if ((busy !== 1'b0) || (done !== 1'b0)) bad++;
            tick();
        end
        check("no partial result after reset", bad, 32'd0);

        // Back-to-back: second start issued in the first op's done cycle.
        run_op("b2b first DIVU 100/7", DIVU_OP, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("b2b second REMU 9/4", REMU_OP, 32'd9, 32'd4, 32'd1, 1'b0);
        tick();
        check("final idle", {30'd0, busy, done}, 32'd0);
        check("final result held", result, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
